of_stage: RTL and testbench

Operand-fetch/decode stage of the 32-bit in-order SimpleRISC pipeline. It consumes the IF/ID packet, decodes the instruction, reads the 16×32 register file, and builds immediates and the branch target. It also detects load-use hazards against the instruction currently in EX and registers a complete OF/EX packet for the EX stage. It owns the architectural register file; WB writes through a dedicated port.

---
 rtl/cpu_pkg.sv | 78 +++++++
 rtl/of_stage_if.sv | 27 ++
 rtl/reg_file.sv | 44 ++++
 rtl/of_stage.sv | 118 +++++++++++
 tb/tb_of_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the SimpleRISC pipeline: IF/ID and OF/EX packets,
// control flags, opcode map and immediate-modifier encodings.
package cpu_pkg;

  localparam int REG_ADDR_WIDTH = 4;
  localparam logic [REG_ADDR_WIDTH-1:0] RA_IDX = 4'd15;

  localparam logic [1:0] IMM_MOD_SEXT = 2'b00;
  localparam logic [1:0] IMM_MOD_ZEXT = 2'b01;
  localparam logic [1:0] IMM_MOD_HIGH = 2'b10;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_MUL  = 5'd2,
    OP_DIV  = 5'd3,
    OP_MOD  = 5'd4,
    OP_CMP  = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOT  = 5'd8,
    OP_MOV  = 5'd9,
    OP_LSL  = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_NOP  = 5'd13,
    OP_LD   = 5'd14,
    OP_ST   = 5'd15,
    OP_BEQ  = 5'd16,
    OP_BGT  = 5'd17,
    OP_B    = 5'd18,
    OP_CALL = 5'd19,
    OP_RET  = 5'd20
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } If_Id_t;

  typedef struct packed {
    logic    is_ld;
    logic    is_st;
    logic    is_beq;
    logic    is_bgt;
    logic    is_ubranch;
    logic    is_ret;
    logic    is_call;
    logic    is_wb;
    logic    is_imm;
    opcode_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0]               pc;
    logic [31:0]               instr;
    logic [31:0]               opA;
    logic [31:0]               opB;
    logic [31:0]               op2;
    logic [31:0]               imm;
    logic [31:0]               branch_target;
    logic [REG_ADDR_WIDTH-1:0] rd;
    ctrl_t                     ctrl;
  } Of_Ex_t;

  // Modifier 11 is unused by the ISA and falls back to sign extension.
  function automatic logic [31:0] gen_imm(input logic [17:0] imm18);
    logic [31:0] r;
    case (imm18[17:16])
      IMM_MOD_SEXT: r = {{16{imm18[15]}}, imm18[15:0]};
      IMM_MOD_ZEXT: r = {16'h0000, imm18[15:0]};
      IMM_MOD_HIGH: r = {imm18[15:0], 16'h0000};
      default:      r = {{16{imm18[15]}}, imm18[15:0]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/of_stage_if.sv
// Pipeline-side bundle of the operand-fetch stage: IF/ID input, stall/flush
// handshakes, WB write port and the OF/EX packet.
interface of_stage_if;
  import cpu_pkg::*;

  logic                      if_valid;
  If_Id_t                    if_payld;
  logic                      of_stall;
  logic                      ex_flush;
  logic                      ex_stall;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [31:0]               wb_data;
  logic                      of_ex_valid;
  Of_Ex_t                    of_ex_payld;

  modport master (
    output if_valid, if_payld, ex_flush, ex_stall, wb_we, wb_rd, wb_data,
    input  of_stall, of_ex_valid, of_ex_payld
  );

  modport slave (
    input  if_valid, if_payld, ex_flush, ex_stall, wb_we, wb_rd, wb_data,
    output of_stall, of_ex_valid, of_ex_payld
  );

endinterface

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports with write-through
// bypass, one write port, synchronous active-low clear of every register.
module reg_file
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] ra_idx,
  input  logic [REG_ADDR_WIDTH-1:0] rb_idx,
  output logic [31:0]               ra_data,
  output logic [31:0]               rb_data,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] wr_idx,
  input  logic [31:0]               wr_data
);

  logic [31:0]               regs_reg [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0] rd_idx   [2];
  logic [31:0]               rd_data  [2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (we) begin
      regs_reg[wr_idx] <= wr_data;
    end
  end

  assign rd_idx[0] = ra_idx;
  assign rd_idx[1] = rb_idx;

  // A same-cycle WB write to the index being read is returned directly.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rd_data[gi] = (we && (wr_idx == rd_idx[gi])) ? wr_data : regs_reg[rd_idx[gi]];
  end

  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];

endmodule

// File: rtl/of_stage.sv
// Operand-fetch/decode stage: decodes the IF/ID packet, reads operands, builds
// immediates and branch targets, detects load-use hazards and registers OF/EX.
module of_stage
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int RA_IDX   = 15
) (
  input logic       clk,
  input logic       rst,
  of_stage_if.slave bus
);

  localparam logic [REG_ADDR_WIDTH-1:0] RA_ADDR = REG_ADDR_WIDTH'(RA_IDX);

  If_Id_t                    ifid;
  logic [4:0]                opc_raw;
  logic                      i_bit;
  logic [REG_ADDR_WIDTH-1:0] rd_f, rs1_f, rs2_f;
  logic [17:0]               imm18;
  logic [26:0]               off27;
  opcode_e                   op;
  logic                      is_alu;
  logic [REG_ADDR_WIDTH-1:0] idx_a, idx_b;
  logic [31:0]               reg_a, reg_b;
  logic [31:0]               imm_val;
  logic                      use_a, use_b;
  logic                      hazard;
  ctrl_t                     ctrl_next;
  Of_Ex_t                    payld_next;
  Of_Ex_t                    payld_reg;
  logic                      valid_reg;

  assign ifid    = bus.if_payld;
  assign opc_raw = ifid.instr[31:27];
  assign i_bit   = ifid.instr[26];
  assign rd_f    = ifid.instr[25:22];
  assign rs1_f   = ifid.instr[21:18];
  assign rs2_f   = ifid.instr[17:14];
  assign imm18   = ifid.instr[17:0];
  assign off27   = ifid.instr[26:0];

  // Unallocated opcodes 21..31 behave exactly like nop.
  assign op      = (opc_raw > 5'd20) ? OP_NOP : opcode_e'(opc_raw);
  assign is_alu  = (opc_raw <= 5'd12);
  assign imm_val = gen_imm(imm18);

  assign idx_a = (op == OP_RET) ? RA_ADDR : rs1_f;
  assign idx_b = (op == OP_ST)  ? rd_f    : rs2_f;

  reg_file #(.NUM_REGS(NUM_REGS)) u_reg_file (
    .clk     (clk),
    .rst     (rst),
    .ra_idx  (idx_a),
    .rb_idx  (idx_b),
    .ra_data (reg_a),
    .rb_data (reg_b),
    .we      (bus.wb_we),
    .wr_idx  (bus.wb_rd),
    .wr_data (bus.wb_data)
  );

  always_comb begin
    ctrl_next            = '0;
    ctrl_next.alu_op     = op;
    ctrl_next.is_imm     = i_bit;
    ctrl_next.is_ld      = (op == OP_LD);
    ctrl_next.is_st      = (op == OP_ST);
    ctrl_next.is_beq     = (op == OP_BEQ);
    ctrl_next.is_bgt     = (op == OP_BGT);
    ctrl_next.is_ubranch = (op == OP_B) || (op == OP_CALL) || (op == OP_RET);
    ctrl_next.is_ret     = (op == OP_RET);
    ctrl_next.is_call    = (op == OP_CALL);
    ctrl_next.is_wb      = is_alu || (op == OP_LD) || (op == OP_CALL);
  end

  always_comb begin
    payld_next               = '0;
    payld_next.pc            = ifid.pc;
    payld_next.instr         = ifid.instr;
    payld_next.opA           = reg_a;
    payld_next.opB           = i_bit ? imm_val : reg_b;
    payld_next.op2           = reg_b;
    payld_next.imm           = imm_val;
    payld_next.branch_target = ifid.pc + {{3{off27[26]}}, off27, 2'b00};
    payld_next.rd            = (op == OP_CALL) ? RA_ADDR : rd_f;
    payld_next.ctrl          = ctrl_next;
  end

  // Port A carries rs1 (or RA for ret); port B carries rs2 for reg-reg ALU ops or rd for st.
  assign use_a = !((op == OP_MOV) || (op == OP_NOT) || (op == OP_NOP) ||
                   (op == OP_B)   || (op == OP_CALL));
  assign use_b = (is_alu && !i_bit) || (op == OP_ST);

  assign hazard = valid_reg && payld_reg.ctrl.is_ld && bus.if_valid &&
                  ((use_a && (payld_reg.rd == idx_a)) || (use_b && (payld_reg.rd == idx_b)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      payld_reg <= '0;
    end else if (bus.ex_flush) begin
      valid_reg <= 1'b0;
    end else if (!bus.ex_stall) begin
      if (hazard) begin
        valid_reg <= 1'b0;
      end else begin
        valid_reg <= bus.if_valid;
        payld_reg <= payld_next;
      end
    end
  end

  assign bus.of_stall    = rst && !bus.ex_flush && (bus.ex_stall || hazard);
  assign bus.of_ex_valid = valid_reg;
  assign bus.of_ex_payld = payld_reg;

endmodule

// File: tb/tb_of_stage.sv
// Scoreboard bench for of_stage: stimulus pushes hand-computed packets, a
// negedge monitor pops and compares each packet EX consumes.
module tb_of_stage;
  import cpu_pkg::*;

  logic clk;
  logic rst;

  of_stage_if bus();

  of_stage #(.NUM_REGS(16), .RA_IDX(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] op2;
    logic [31:0] tgt;
    logic [3:0]  rd;
    logic        is_wb;
    logic        chk_ops;
    logic        chk_op2;
    logic        chk_tgt;
  } exp_t;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

  logic [31:0] mov_exp [4] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
  endtask

  function automatic logic [31:0] enc(input opcode_e op, input logic i, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [17:0] low);
    return {op, i, rd, rs1, low};
  endfunction

  function automatic logic [31:0] encb(input opcode_e op, input logic [26:0] off);
    return {op, off};
  endfunction

  task automatic push(input string name, input logic [31:0] pc, input logic [31:0] op_a,
                      input logic [31:0] op_b, input logic [31:0] op2, input logic [31:0] tgt,
                      input logic [3:0] rd, input logic is_wb, input logic chk_ops,
                      input logic chk_op2, input logic chk_tgt);
    exp_t e;
    e.name = name; e.pc = pc; e.op_a = op_a; e.op_b = op_b; e.op2 = op2; e.tgt = tgt;
    e.rd = rd; e.is_wb = is_wb; e.chk_ops = chk_ops; e.chk_op2 = chk_op2; e.chk_tgt = chk_tgt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_payld = {pc, instr};
  endtask

  task automatic wb(input logic [3:0] r, input logic [31:0] d);
    bus.wb_we   = 1'b1;
    bus.wb_rd   = r;
    bus.wb_data = d;
  endtask

  // EX consumes the OF/EX packet at the next edge when it is valid and not stalled.
  always @(negedge clk) begin
    if (rst && bus.of_ex_valid && !bus.ex_stall) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_packet: got pc=0x%08h required no packet", bus.of_ex_payld.pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("pkt %s pc=0x%08h opA=0x%08h opB=0x%08h rd=%0d", e.name, bus.of_ex_payld.pc,
                 bus.of_ex_payld.opA, bus.of_ex_payld.opB, bus.of_ex_payld.rd);
        chk({e.name, ".pc"}, bus.of_ex_payld.pc, e.pc);
        chk({e.name, ".rd"}, 32'(bus.of_ex_payld.rd), 32'(e.rd));
        chk({e.name, ".is_wb"}, 32'(bus.of_ex_payld.ctrl.is_wb), 32'(e.is_wb));
        if (e.chk_ops) begin
          chk({e.name, ".opA"}, bus.of_ex_payld.opA, e.op_a);
          chk({e.name, ".opB"}, bus.of_ex_payld.opB, e.op_b);
        end
        if (e.chk_op2) chk({e.name, ".op2"}, bus.of_ex_payld.op2, e.op2);
        if (e.chk_tgt) chk({e.name, ".target"}, bus.of_ex_payld.branch_target, e.tgt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_payld = {32'h0, enc(OP_ADD, 1'b0, 4'd1, 4'd1, 18'd0)};
    bus.ex_flush = 1'b0;
    bus.ex_stall = 1'b1;
    bus.wb_we    = 1'b0;
    bus.wb_rd    = 4'd0;
    bus.wb_data  = 32'd0;

    // Reset holds of_stall low even with ex_stall raised.
    @(negedge clk);
    chk("reset_of_stall", 32'(bus.of_stall), 32'd0);
    chk("reset_valid", 32'(bus.of_ex_valid), 32'd0);
    step();
    rst = 1'b1; bus.ex_stall = 1'b0; bus.if_valid = 1'b0;

    wb(4'd1, 32'h5);   step();
    wb(4'd5, 32'h200); step();
    wb(4'd3, 32'h11);  step();
    bus.wb_we = 1'b0;

    // add r1,r3,r3 one cycle after r3 is written
    issue(32'h0, enc(OP_ADD, 1'b0, 4'd1, 4'd3, {4'd3, 14'd0}));
    push("add_r3", 32'h0, 32'h11, 32'h11, 32'h0, 32'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    bus.if_valid = 1'b0;
    @(negedge clk);
    chk("add_latency", 32'(bus.of_ex_valid), 32'd1);
    step();

    // mov r2,#0xFFFF with each immediate modifier, back to back
    for (int m = 0; m < 4; m++) begin
      issue(32'h10 + 32'(4 * m), enc(OP_MOV, 1'b1, 4'd2, 4'd0, {2'(m), 16'hFFFF}));
      push("mov_imm", 32'h10 + 32'(4 * m), 32'h0, mov_exp[m], 32'h0, 32'h0, 4'd2, 1'b1,
           1'b1, 1'b0, 1'b0);
      step();
    end

    // branch targets, including wrap-around, and call writing RA
    issue(32'h100, encb(OP_B, 27'h7FF_FFFF));
    push("b_back", 32'h100, 0, 0, 0, 32'h0000_00FC, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    issue(32'hFFFF_FFFC, encb(OP_B, 27'd1));
    push("b_wrap", 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    issue(32'h40, encb(OP_CALL, 27'd4));
    push("call", 32'h40, 0, 0, 0, 32'h50, 4'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    bus.if_valid = 1'b0;
    step();

    // ld r4,[r5] then dependent add r6,r4,r1
    issue(32'h200, enc(OP_LD, 1'b1, 4'd4, 4'd5, 18'd0));
    push("ld1", 32'h200, 32'h200, 32'h0, 32'h0, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    issue(32'h204, enc(OP_ADD, 1'b0, 4'd6, 4'd4, {4'd1, 14'd0}));
    @(negedge clk);
    chk("ld_use_stall", 32'(bus.of_stall), 32'd1);
    step();
    @(negedge clk);
    chk("ld_use_bubble", 32'(bus.of_ex_valid), 32'd0);
    chk("ld_use_stall_clears", 32'(bus.of_stall), 32'd0);
    push("add_after_ld", 32'h204, 32'h0, 32'h5, 32'h0, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step();

    // ld followed by an independent add
    issue(32'h208, enc(OP_LD, 1'b1, 4'd4, 4'd5, 18'd0));
    push("ld2", 32'h208, 32'h200, 32'h0, 32'h0, 32'h0, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    issue(32'h20C, enc(OP_ADD, 1'b0, 4'd6, 4'd1, {4'd1, 14'd0}));
    @(negedge clk);
    chk("indep_no_stall", 32'(bus.of_stall), 32'd0);
    push("add_indep", 32'h20C, 32'h5, 32'h5, 32'h0, 32'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    bus.if_valid = 1'b0;
    step();

    // flush coinciding with hazard and ex_stall
    issue(32'h300, enc(OP_LD, 1'b1, 4'd4, 4'd5, 18'd0));
    step();
    issue(32'h304, enc(OP_ADD, 1'b0, 4'd6, 4'd4, {4'd1, 14'd0}));
    bus.ex_stall = 1'b1; bus.ex_flush = 1'b1;
    @(negedge clk);
    chk("flush_of_stall", 32'(bus.of_stall), 32'd0);
    step();
    bus.ex_stall = 1'b0; bus.ex_flush = 1'b0; bus.if_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(bus.of_ex_valid), 32'd0);
    step();

    // same-cycle WB write and read of r7, then st reading r7 through port B
    wb(4'd7, 32'hCAFE_F00D);
    issue(32'h400, enc(OP_ADD, 1'b0, 4'd8, 4'd7, {4'd7, 14'd0}));
    push("bypass_r7", 32'h400, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 32'h0, 4'd8, 1'b1,
         1'b1, 1'b0, 1'b0);
    step();
    bus.wb_we = 1'b0;
    issue(32'h404, enc(OP_ST, 1'b1, 4'd7, 4'd1, 18'd4));
    push("st_r7", 32'h404, 32'h5, 32'h4, 32'hCAFE_F00D, 32'h0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    bus.if_valid = 1'b0;
    step();

    // reset asserted while a stall is pending
    issue(32'h500, enc(OP_LD, 1'b1, 4'd4, 4'd5, 18'd0));
    step();
    rst = 1'b0; bus.ex_stall = 1'b1;
    issue(32'h504, enc(OP_ADD, 1'b0, 4'd6, 4'd4, {4'd1, 14'd0}));
    @(negedge clk);
    chk("rst_mid_stall_of_stall", 32'(bus.of_stall), 32'd0);
    step();
    rst = 1'b1; bus.ex_stall = 1'b0;
    issue(32'h508, enc(OP_ADD, 1'b0, 4'd9, 4'd5, {4'd3, 14'd0}));
    push("regs_cleared", 32'h508, 32'h0, 32'h0, 32'h0, 32'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_valid", 32'(bus.of_ex_valid), 32'd0);
    chk("rst_of_stall", 32'(bus.of_stall), 32'd0);
    step();
    issue(32'h50C, enc(OP_ST, 1'b1, 4'd7, 4'd1, 18'd4));
    push("st_cleared", 32'h50C, 32'h0, 32'h4, 32'h0, 32'h0, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    bus.if_valid = 1'b0;
    step();
    step();

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
